// File: rtl/rf_adc_frame_capture.sv
// Multi-channel ADC frame capture: arm, trigger, decimate and frame ADC beats
// onto per-channel AXI-Stream masters with sticky overflow on output stalls.
module rf_adc_frame_capture #(
  parameter int CH_NUM   = 6,
  parameter int AXIS_WID = 128,
  parameter int LEN_WID  = 16,
  parameter int DEC_WID  = 8,
  parameter int CNT_WID  = 16
) (
  input  logic                         clk_adc,
  input  logic                         adc_rstb,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trig_mode,
  input  logic                         cont,
  input  logic                         trig_in,
  input  logic [CH_NUM-1:0]            ch_en,
  input  logic [LEN_WID-1:0]           frame_len,
  input  logic [DEC_WID-1:0]           dec_ratio,
  input  logic [CH_NUM*AXIS_WID-1:0]   s_tdata,
  input  logic [CH_NUM-1:0]            s_tvalid,
  output logic [CH_NUM-1:0]            s_tready,
  output logic [CH_NUM*AXIS_WID-1:0]   m_tdata,
  output logic [CH_NUM-1:0]            m_tvalid,
  input  logic [CH_NUM-1:0]            m_tready,
  output logic [CH_NUM-1:0]            m_tlast,
  output logic [1:0]                   state,
  output logic [CH_NUM-1:0]            overflow,
  output logic [CNT_WID-1:0]           frame_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          st;
  logic [CH_NUM-1:0]   en_q;
  logic [LEN_WID-1:0]  len_q;
  logic [DEC_WID-1:0]  dec_q;
  logic                trig_d;
  logic [DEC_WID-1:0]  dec_cnt;
  logic [LEN_WID-1:0]  beat_cnt;

  logic                strobe;
  logic                kept;
  logic                last_beat;
  logic                arm_ok;
  logic                trig_hit;
  logic                dec_wrap;
  logic [LEN_WID-1:0]  last_idx;

  assign s_tready = '1;
  assign state    = st;

  // Disabled channels are masked out so they never stall the strobe.
  assign strobe    = &(s_tvalid | ~en_q);
  assign kept      = (st == S_CAPTURE) && !abort && strobe && (dec_cnt == '0);
  assign last_idx  = (len_q == '0) ? '0 : len_q - LEN_WID'(1);
  assign last_beat = kept && (beat_cnt == last_idx);
  assign arm_ok    = arm && (ch_en != '0) && ((st == S_IDLE) || (st == S_DONE));
  assign trig_hit  = trig_mode || (trig_in && !trig_d);
  assign dec_wrap  = (dec_q <= DEC_WID'(1)) || (dec_cnt == dec_q - DEC_WID'(1));

  always_ff @(posedge clk_adc or negedge adc_rstb) begin
    if (!adc_rstb) begin
      st        <= S_IDLE;
      en_q      <= '0;
      len_q     <= '0;
      dec_q     <= '0;
      trig_d    <= 1'b0;
      dec_cnt   <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      trig_d <= trig_in;
      if (abort) begin
        st <= S_IDLE;
      end else begin
        case (st)
          S_IDLE, S_DONE: begin
            if (arm_ok) begin
              en_q      <= ch_en;
              len_q     <= frame_len;
              dec_q     <= dec_ratio;
              frame_cnt <= '0;
              st        <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trig_hit) begin
              dec_cnt  <= '0;
              beat_cnt <= '0;
              st       <= S_CAPTURE;
            end
          end
          default: begin
            if (strobe) dec_cnt <= dec_wrap ? '0 : dec_cnt + DEC_WID'(1);
            if (last_beat) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + CNT_WID'(1);
              st        <= cont ? S_ARMED : S_DONE;
            end else if (kept) begin
              beat_cnt <= beat_cnt + LEN_WID'(1);
            end
          end
        endcase
      end
    end
  end

  // A stalled channel keeps its held beat; the beat counter still advances
  // so all channels stay frame-aligned.
  always_ff @(posedge clk_adc or negedge adc_rstb) begin
    if (!adc_rstb) begin
      m_tdata  <= '0;
      m_tvalid <= '0;
      m_tlast  <= '0;
      overflow <= '0;
    end else begin
      if (arm_ok && !abort) overflow <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        if (kept && en_q[k]) begin
          if (m_tvalid[k] && !m_tready[k]) begin
            overflow[k] <= 1'b1;
          end else begin
            m_tvalid[k]                      <= 1'b1;
            m_tlast[k]                       <= last_beat;
            m_tdata[k*AXIS_WID +: AXIS_WID]  <= s_tdata[k*AXIS_WID +: AXIS_WID];
          end
        end else if (m_tvalid[k] && m_tready[k]) begin
          m_tvalid[k] <= 1'b0;
          m_tlast[k]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_adc_frame_capture.sv
// Bench for rf_adc_frame_capture: table of single-frame captures plus
// hand sequences for continuous mode, overflow, abort and async reset.
module tb_rf_adc_frame_capture;

  localparam int CH_NUM   = 6;
  localparam int AXIS_WID = 128;
  localparam int LEN_WID  = 16;
  localparam int DEC_WID  = 8;
  localparam int CNT_WID  = 16;

  logic                        clk_adc;
  logic                        adc_rstb;
  logic                        arm, abort, trig_mode, cont, trig_in;
  logic [CH_NUM-1:0]           ch_en;
  logic [LEN_WID-1:0]          frame_len;
  logic [DEC_WID-1:0]          dec_ratio;
  logic [CH_NUM*AXIS_WID-1:0]  s_tdata;
  logic [CH_NUM-1:0]           s_tvalid;
  logic [CH_NUM-1:0]           s_tready;
  logic [CH_NUM*AXIS_WID-1:0]  m_tdata;
  logic [CH_NUM-1:0]           m_tvalid;
  logic [CH_NUM-1:0]           m_tready;
  logic [CH_NUM-1:0]           m_tlast;
  logic [1:0]                  state;
  logic [CH_NUM-1:0]           overflow;
  logic [CNT_WID-1:0]          frame_cnt;

  rf_adc_frame_capture #(
    .CH_NUM(CH_NUM), .AXIS_WID(AXIS_WID), .LEN_WID(LEN_WID),
    .DEC_WID(DEC_WID), .CNT_WID(CNT_WID)
  ) dut (
    .clk_adc(clk_adc), .adc_rstb(adc_rstb), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .cont(cont), .trig_in(trig_in), .ch_en(ch_en),
    .frame_len(frame_len), .dec_ratio(dec_ratio), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .state(state), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  // clock / reset
  initial clk_adc = 1'b0;
  always #5 clk_adc = ~clk_adc;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] samp;
  logic [CH_NUM-1:0] cur_mask;
  logic        mon_on;
  logic [32:0] exp_q[$];   // {tlast, sample index}

  typedef struct {
    logic [CH_NUM-1:0]  ch_en;
    logic [LEN_WID-1:0] len;
    logic [DEC_WID-1:0] dec;
    logic               mode;
    int                 trig_dly;
    logic [1:0]         exp_state;
    logic [CNT_WID-1:0] exp_fc;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [AXIS_WID-1:0] mk(input logic [31:0] s, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    mk = {{(AXIS_WID-40){1'b0}}, s, kb};
  endfunction

  task automatic check(input string name, input logic [AXIS_WID-1:0] got,
                       input logic [AXIS_WID-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ADC source: sample index advances every cycle, stamped with channel id
  initial begin
    samp = 0;
    for (int k = 0; k < CH_NUM; k++) s_tdata[k*AXIS_WID +: AXIS_WID] = mk(samp, k);
    forever begin
      @(posedge clk_adc);
      #1;
      samp = samp + 1;
      for (int k = 0; k < CH_NUM; k++) s_tdata[k*AXIS_WID +: AXIS_WID] = mk(samp, k);
    end
  end

  // scoreboard: one expected entry per handshake across all enabled channels
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_adc);
      #1;
      if (mon_on) begin
        for (int k = 0; k < CH_NUM; k++)
          if (!cur_mask[k]) check("disabled_tvalid", AXIS_WID'(m_tvalid[k]), '0);
        if ((m_tvalid & m_tready & cur_mask) != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", AXIS_WID'(m_tvalid & cur_mask), '0);
          end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < CH_NUM; k++) begin
              if (cur_mask[k]) begin
                check("beat_valid", AXIS_WID'(m_tvalid[k] & m_tready[k]), AXIS_WID'(1));
                check("beat_data", m_tdata[k*AXIS_WID +: AXIS_WID], mk(e[31:0], k));
                check("beat_last", AXIS_WID'(m_tlast[k]), AXIS_WID'(e[32]));
              end
            end
          end
        end
      end
    end
  end

  task automatic do_arm(input logic [CH_NUM-1:0] en, input logic [LEN_WID-1:0] len,
                        input logic [DEC_WID-1:0] dec, input logic mode,
                        input logic c, output logic [31:0] s_arm);
    @(negedge clk_adc);
    ch_en = en; frame_len = len; dec_ratio = dec; trig_mode = mode; cont = c;
    arm = 1'b1;
    s_arm = samp;
    @(negedge clk_adc);
    arm = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input logic last);
    exp_q.push_back({last, s});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_adc);
      n++;
    end
    check("drain_timeout", AXIS_WID'(exp_q.size()), '0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_adc);
    #2;
  endtask

  initial begin
    logic [31:0] s_arm;
    logic [31:0] e0;
    int d_eff, l_eff;

    adc_rstb = 1'b0; arm = 0; abort = 0; trig_mode = 0; cont = 0; trig_in = 0;
    ch_en = '0; frame_len = '0; dec_ratio = '0;
    s_tvalid = '1; m_tready = '1; mon_on = 1'b0; cur_mask = '1;

    #12;
    check("rst_state", AXIS_WID'(state), '0);
    check("rst_tvalid", AXIS_WID'(m_tvalid), '0);
    check("rst_tlast", AXIS_WID'(m_tlast), '0);
    check("rst_tdata", m_tdata[AXIS_WID-1:0], '0);
    check("rst_overflow", AXIS_WID'(overflow), '0);
    check("rst_frame_cnt", AXIS_WID'(frame_cnt), '0);
    #11 adc_rstb = 1'b1;
    #3;
    check("s_tready_ones", AXIS_WID'(s_tready), AXIS_WID'({CH_NUM{1'b1}}));
    mon_on = 1'b1;

    // {ch_en, len, dec, mode, trig_dly, exp_state, exp_fc}
    tbl[0] = '{6'h00, 16'd4, 8'd1, 1'b1, 0,  2'd0, 16'd0};
    tbl[1] = '{6'h3F, 16'd4, 8'd1, 1'b1, 0,  2'd3, 16'd1};
    tbl[2] = '{6'h3F, 16'd5, 8'd3, 1'b0, 10, 2'd3, 16'd1};
    tbl[3] = '{6'h3F, 16'd0, 8'd0, 1'b1, 0,  2'd3, 16'd1};
    tbl[4] = '{6'h21, 16'd3, 8'd2, 1'b1, 0,  2'd3, 16'd1};

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].ch_en != '0) cur_mask = tbl[i].ch_en;
      do_arm(tbl[i].ch_en, tbl[i].len, tbl[i].dec, tbl[i].mode, 1'b0, s_arm);
      if (tbl[i].ch_en != '0) begin
        d_eff = (tbl[i].dec <= 1) ? 1 : int'(tbl[i].dec);
        l_eff = (tbl[i].len == 0) ? 1 : int'(tbl[i].len);
        e0 = tbl[i].mode ? s_arm + 2 : s_arm + 32'(tbl[i].trig_dly) + 1;
        for (int j = 0; j < l_eff; j++) push(e0 + 32'(j * d_eff), j == l_eff - 1);
        if (!tbl[i].mode) begin
          repeat (tbl[i].trig_dly - 1) @(negedge clk_adc);
          trig_in = 1'b1;
          @(negedge clk_adc);
          trig_in = 1'b0;
        end
      end
      wait_drain();
      settle();
      check("tbl_state", AXIS_WID'(state), AXIS_WID'(tbl[i].exp_state));
      check("tbl_frame_cnt", AXIS_WID'(frame_cnt), AXIS_WID'(tbl[i].exp_fc));
      check("tbl_overflow", AXIS_WID'(overflow), '0);
    end

    // continuous mode: three 2-beat frames, one ARMED cycle between frames
    cur_mask = 6'h3F;
    do_arm(6'h3F, 16'd2, 8'd1, 1'b1, 1'b1, s_arm);
    push(s_arm + 2, 0); push(s_arm + 3, 1);
    push(s_arm + 5, 0); push(s_arm + 6, 1);
    push(s_arm + 8, 0); push(s_arm + 9, 1);
    repeat (9) @(negedge clk_adc);
    #2;
    check("cont_frame_cnt", AXIS_WID'(frame_cnt), AXIS_WID'(3));
    abort = 1'b1;
    @(negedge clk_adc);
    abort = 1'b0; cont = 1'b0;
    #2;
    check("cont_abort_state", AXIS_WID'(state), '0);
    check("cont_abort_fc", AXIS_WID'(frame_cnt), AXIS_WID'(3));
    check("cont_all_beats", AXIS_WID'(exp_q.size()), '0);

    // back-pressure overflow on channel 0, stalled for three cycles
    cur_mask = 6'h01;
    do_arm(6'h01, 16'd8, 8'd1, 1'b1, 1'b0, s_arm);
    push(s_arm + 2, 0); push(s_arm + 3, 0);
    push(s_arm + 7, 0); push(s_arm + 8, 0); push(s_arm + 9, 1);
    repeat (3) @(negedge clk_adc);
    m_tready[0] = 1'b0;
    @(negedge clk_adc);
    #2;
    check("ovf_held_valid", AXIS_WID'(m_tvalid[0]), AXIS_WID'(1));
    check("ovf_held_data", m_tdata[AXIS_WID-1:0], mk(s_arm + 3, 0));
    repeat (2) @(negedge clk_adc);
    m_tready[0] = 1'b1;
    wait_drain();
    settle();
    check("ovf_flags", AXIS_WID'(overflow), AXIS_WID'(6'h01));
    check("ovf_state", AXIS_WID'(state), AXIS_WID'(3));
    check("ovf_frame_cnt", AXIS_WID'(frame_cnt), AXIS_WID'(1));

    // abort mid-frame while a beat is held
    cur_mask = 6'h3F;
    do_arm(6'h3F, 16'd6, 8'd1, 1'b1, 1'b0, s_arm);
    push(s_arm + 2, 0); push(s_arm + 3, 0); push(s_arm + 4, 0);
    repeat (4) @(negedge clk_adc);
    m_tready = '0; abort = 1'b1;
    @(negedge clk_adc);
    abort = 1'b0;
    #2;
    check("abort_state", AXIS_WID'(state), '0);
    check("abort_held_valid", AXIS_WID'(m_tvalid), AXIS_WID'(6'h3F));
    check("abort_no_tlast", AXIS_WID'(m_tlast), '0);
    repeat (3) @(negedge clk_adc);
    #2;
    check("abort_still_valid", AXIS_WID'(m_tvalid), AXIS_WID'(6'h3F));
    @(negedge clk_adc);
    m_tready = '1;
    wait_drain();
    settle();
    check("abort_no_more", AXIS_WID'(m_tvalid), '0);
    check("abort_overflow", AXIS_WID'(overflow), '0);
    check("abort_frame_cnt", AXIS_WID'(frame_cnt), '0);

    // async reset asserted mid-capture, away from any clock edge
    mon_on = 1'b0;
    do_arm(6'h3F, 16'd8, 8'd1, 1'b1, 1'b0, s_arm);
    repeat (3) @(negedge clk_adc);
    #2 adc_rstb = 1'b0;
    #1;
    check("arst_tvalid", AXIS_WID'(m_tvalid), '0);
    check("arst_tlast", AXIS_WID'(m_tlast), '0);
    check("arst_tdata", m_tdata[AXIS_WID-1:0], '0);
    check("arst_state", AXIS_WID'(state), '0);
    check("arst_frame_cnt", AXIS_WID'(frame_cnt), '0);
    check("arst_overflow", AXIS_WID'(overflow), '0);
    #10 adc_rstb = 1'b1;
    settle();
    check("post_rst_state", AXIS_WID'(state), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
